uart_tx_fifo_p: RTL and testbench
=================================

Name: uart_tx_fifo_p

Overview:
Parametrised next-generation UART transmitter for the ICB register path. It adds a TX FIFO, programmable frame format (5-8 data bits, optional odd/even parity, 1 or 2 stop bits), and maskable sticky interrupt sources. The baud tick is derived from sys_clk by a programmable divider, so the block has a single clock domain. It sits behind the register decode, which drives the *_wr strobes and icb_wdat.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; power of 2, 2..128
BAUD_W, 16, width of the baud divisor register

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
uart_baud_wr  in  1  1-cycle strobe: uart_baud <= icb_wdat[BAUD_W-1:0]
uart_con_wr  in  1  1-cycle strobe: uart_con <= icb_wdat
uart_txbuf_wr  in  1  1-cycle strobe: push icb_wdat[7:0] into the FIFO
uart_sta_wr  in  1  1-cycle strobe: write-1-to-clear of uart_sta[2:0]
icb_wdat  in  16  register write data
uart_con  out  16  control register readback
uart_baud  out  BAUD_W  divisor readback
uart_sta  out  16  status register
uart_tx  out  1  serial output, idle high
uart_en  out  1  equals uart_con[0]
uart_int  out  1  level interrupt

Behaviour:
- Reset: uart_con=0, uart_baud=0, uart_sta=0 (FIFO empty), uart_tx=1, uart_int=0, FSM=IDLE, FIFO pointers and count=0.
- uart_con fields:
  - [0] en
  - [1] parity_en
  - [2] parity_odd
  - [3] stop2
  - [5:4] dlen: 00=5, 01=6, 10=7, 11=8 data bits
  - [6] ie_done
  - [7] ie_empty
  - [8] ie_ovf
  - [9] flush: self-clearing. Empties the FIFO next cycle; an in-flight frame still completes. Reads back 0.
  - [15:10] reserved, read 0.
- uart_sta fields:
  - [0] done: sticky, set on the last stop-bit cycle
  - [1] empty_evt: sticky, set when a pop leaves the FIFO empty
  - [2] ovf: sticky, set on a push while full; the push is dropped
  - [3] busy: FSM not IDLE
  - [4] full
  - [5] empty
  - [15:8] FIFO count
- Sticky bits clear on uart_sta_wr where icb_wdat bit=1. A set event in the same cycle as a clear wins (bit stays 1).
- uart_int = |(uart_sta[2:0] & uart_con[8:6]), registered (1 cycle after the flag).
- Bit period = uart_baud+1 sys_clk cycles; uart_baud=0 gives 1 cycle/bit.
- FIFO behaviour:
  - The count used for the full check is the pre-pop value, so a push at full in the same cycle as a pop is dropped and sets ovf.
  - A push at cycle N is visible (count, empty) at N+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when en=1 and FIFO non-empty, pop the head and latch data, dlen, parity_en, parity_odd, stop2 and uart_baud into shadow registers. Go to START; uart_tx=0 from the next cycle.
  - START: 1 bit period, then DATA.
  - DATA: dlen bits, LSB first; bits above dlen are ignored. Then PARITY if parity_en, else STOP.
  - PARITY: bit = XOR of sent data bits, inverted if parity_odd.
  - STOP: uart_tx=1 for 1 or 2 bit periods, then IDLE. Back-to-back frames: the next START begins the cycle after STOP ends (pop in that IDLE cycle).
- Writes to uart_con or uart_baud mid-frame affect only the next frame, via the shadows.
- Clearing en mid-frame completes the current frame; the FIFO is retained.
- sys_rst mid-frame: uart_tx=1 on the next cycle and all state returns to reset values.

Test Plan:
- Reset values: hold sys_rst for 5 cycles -> uart_tx=1, uart_sta=16'h0020, uart_int=0, uart_con=0, uart_baud=0.
- 8N1 frame: baud=3, con=16'h0031, push 8'hA5 -> uart_tx 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). done sets on the last stop cycle; uart_int=1 one cycle later.
- Format variants: con dlen=10, parity_en, odd, stop2, push 8'hA5 -> 7 data bits of 8'h25, parity bit 0 (three ones, odd), 2 stop bits, 11 bit periods. With even parity the parity bit is 1.
- FIFO overflow and depth: en=0, push 17 bytes with FIFO_DEPTH=16 -> count=16, full=1, ovf=1, byte 17 lost. Set en=1 -> 16 back-to-back frames in order. empty_evt sets after the 16th pop.
- Mid-frame changes: write baud=7 during frame 1 of 2 -> frame 1 keeps 4 cycles/bit and frame 2 uses 8 cycles/bit. Flush during frame 1 -> frame 1 completes and no frame 2 is sent.
- Clear collision: uart_sta_wr with icb_wdat=16'h0001 in the same cycle done is set -> done remains 1. A later clear with no event -> done=0 and uart_int drops the next cycle.

Source files
------------

// File: rtl/uart_tx_fifo_p.sv
// UART transmitter with TX FIFO, programmable frame format (5-8 data bits, optional odd/even
// parity, 1 or 2 stop bits), programmable baud divisor and maskable sticky interrupt sources.
// Frame parameters are captured into shadow registers at pop time, so register writes made
// mid-frame only take effect from the next frame onwards.
module uart_tx_fifo_p #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BAUD_W     = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              uart_baud_wr,
    input  logic              uart_con_wr,
    input  logic              uart_txbuf_wr,
    input  logic              uart_sta_wr,
    input  logic [15:0]       icb_wdat,
    output logic [15:0]       uart_con,
    output logic [BAUD_W-1:0] uart_baud,
    output logic [15:0]       uart_sta,
    output logic              uart_tx,
    output logic              uart_en,
    output logic              uart_int
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // Control / divisor registers (flush bit is never stored, so it reads back 0)
    logic [8:0]        con_q, con_d;
    logic [BAUD_W-1:0] baud_q, baud_d;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, flush, push_ok, pop;

    // Sticky flags {ovf, empty_evt, done} and registered interrupt
    logic [2:0] sticky_q, sticky_d;
    logic       int_q, int_d;
    logic       done_evt, empty_evt, ovf_evt;

    // Transmit FSM and per-frame shadows
    state_e            state_q, state_d;
    logic [BAUD_W-1:0] cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        dlen_q, dlen_d;
    logic              pen_q, pen_d;
    logic              par_q, par_d;
    logic              stop2_q, stop2_d;
    logic [BAUD_W-1:0] baud_s_q, baud_s_d;
    logic              tx_q, tx_d;

    logic              bit_end;
    logic [7:0]        dmask;
    logic [7:0]        head_masked;

    // Reserved control bits are accepted on the bus but have no function
    logic unused_wdat;
    assign unused_wdat = ^icb_wdat[15:10];

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign flush   = uart_con_wr & icb_wdat[9];
    assign push_ok = uart_txbuf_wr & ~full;
    assign pop     = (state_q == StIdle) & con_q[0] & ~empty;

    // Register writes and FIFO pointer / count update; flush overrides everything else
    always_comb begin
        con_d    = con_q;
        baud_d   = baud_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        if (uart_con_wr) begin
            con_d = icb_wdat[8:0];
        end
        if (uart_baud_wr) begin
            baud_d = BAUD_W'(icb_wdat);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Transmit FSM: next state, bit timing, shadow capture and serial output
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        dlen_d   = dlen_q;
        pen_d    = pen_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        baud_s_d = baud_s_q;
        done_evt = 1'b0;
        tx_d     = 1'b1;
        bit_end  = (cnt_q == baud_s_q);

        unique case (con_q[5:4])
            2'b00:   dmask = 8'h1f;
            2'b01:   dmask = 8'h3f;
            2'b10:   dmask = 8'h7f;
            default: dmask = 8'hff;
        endcase
        head_masked = mem_q[rd_ptr_q] & dmask;

        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d  = StStart;
                    cnt_d    = '0;
                    bit_d    = '0;
                    shift_d  = head_masked;
                    dlen_d   = con_q[5:4];
                    pen_d    = con_q[1];
                    par_d    = (^head_masked) ^ con_q[2];
                    stop2_d  = con_q[3];
                    baud_s_d = baud_q;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == ({1'b0, dlen_q} + 3'd4)) begin
                        bit_d   = '0;
                        state_d = pen_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (stop2_q && (bit_q == 3'd0)) begin
                        bit_d = 3'd1;
                    end else begin
                        bit_d    = '0;
                        state_d  = StIdle;
                        done_evt = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Output follows the state being entered so uart_tx is a clean flop output
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // Sticky status: a set event in the same cycle as a write-1-to-clear wins
    always_comb begin
        ovf_evt   = uart_txbuf_wr & full;
        empty_evt = pop & (count_q == CW'(1)) & ~push_ok;
        sticky_d  = {ovf_evt, empty_evt, done_evt} |
                    (sticky_q & ~(uart_sta_wr ? icb_wdat[2:0] : 3'b000));
        int_d     = |(sticky_q & con_q[8:6]);
    end

    // FIFO data storage; contents need no reset
    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= icb_wdat[7:0];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            con_q    <= '0;
            baud_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
            int_q    <= 1'b0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            dlen_q   <= '0;
            pen_q    <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            baud_s_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            con_q    <= con_d;
            baud_q   <= baud_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            int_q    <= int_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            dlen_q   <= dlen_d;
            pen_q    <= pen_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            baud_s_q <= baud_s_d;
            tx_q     <= tx_d;
        end
    end

    assign uart_con  = {7'b0, con_q};
    assign uart_baud = baud_q;
    assign uart_en   = con_q[0];
    assign uart_int  = int_q;
    assign uart_tx   = tx_q;
    assign uart_sta  = {8'(count_q), 2'b00, empty, full, (state_q != StIdle), sticky_q};

endmodule

// File: tb/tb_uart_tx_fifo_p.sv
// Scoreboard bench for uart_tx_fifo_p: stimulus pushes expected frames (bit sequence, bit
// period, back-to-back flag) into a queue; a monitor detects start bits on uart_tx, pops the
// next expected frame and checks every cycle of every bit.
module tb_uart_tx_fifo_p;

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned BAUD_W     = 16;

    localparam int SelBaud  = 0;
    localparam int SelCon   = 1;
    localparam int SelTxbuf = 2;
    localparam int SelSta   = 3;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              uart_baud_wr;
    logic              uart_con_wr;
    logic              uart_txbuf_wr;
    logic              uart_sta_wr;
    logic [15:0]       icb_wdat;
    logic [15:0]       uart_con;
    logic [BAUD_W-1:0] uart_baud;
    logic [15:0]       uart_sta;
    logic              uart_tx;
    logic              uart_en;
    logic              uart_int;

    typedef struct {
        int          baud;
        int          nbits;
        logic [11:0] seq;   // seq[0] is transmitted first
        bit          btb;   // next frame must follow after exactly one idle cycle
    } frame_t;

    frame_t exp_q[$];
    int     n_checks    = 0;
    int     n_fail      = 0;
    int     frames_done = 0;
    int     frame_idx   = 0;

    uart_tx_fifo_p #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .BAUD_W    (BAUD_W)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .uart_baud_wr (uart_baud_wr),
        .uart_con_wr  (uart_con_wr),
        .uart_txbuf_wr(uart_txbuf_wr),
        .uart_sta_wr  (uart_sta_wr),
        .icb_wdat     (icb_wdat),
        .uart_con     (uart_con),
        .uart_baud    (uart_baud),
        .uart_sta     (uart_sta),
        .uart_tx      (uart_tx),
        .uart_en      (uart_en),
        .uart_int     (uart_int)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Called between a negedge and the next posedge; returns at the following negedge
    task automatic reg_wr(input int sel, input logic [15:0] d);
        icb_wdat = d;
        case (sel)
            SelBaud:  uart_baud_wr  = 1'b1;
            SelCon:   uart_con_wr   = 1'b1;
            SelTxbuf: uart_txbuf_wr = 1'b1;
            default:  uart_sta_wr   = 1'b1;
        endcase
        @(negedge sys_clk);
        uart_baud_wr  = 1'b0;
        uart_con_wr   = 1'b0;
        uart_txbuf_wr = 1'b0;
        uart_sta_wr   = 1'b0;
        icb_wdat      = '0;
    endtask

    task automatic expect_frame(input int baud, input int nbits, input logic [11:0] seq,
                                input bit btb);
        frame_t f;
        f.baud  = baud;
        f.nbits = nbits;
        f.seq   = seq;
        f.btb   = btb;
        exp_q.push_back(f);
    endtask

    // Returns at negedge+1 of the cycle in which the monitor saw the target frame end
    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        chk(name, 32'(frames_done >= target), 1);
    endtask

    // Monitor: frame checker driven purely by uart_tx
    initial begin : monitor
        frame_t f;
        bit     started = 1'b0;
        bit     ok;
        logic   got_bit;
        forever begin
            if (!started) begin
                @(negedge sys_clk);
                if (sys_rst !== 1'b0 || uart_tx !== 1'b0) continue;
            end
            started = 1'b0;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame: start bit at %0t, got uart_tx=0, expected idle 1",
                         $time);
                for (int i = 0; i < 4000 && uart_tx === 1'b0; i++) @(negedge sys_clk);
                continue;
            end
            f = exp_q.pop_front();
            for (int b = 0; b < f.nbits; b++) begin
                ok      = 1'b1;
                got_bit = f.seq[b];
                for (int c = 0; c <= f.baud; c++) begin
                    if (b != 0 || c != 0) @(negedge sys_clk);
                    if (ok && uart_tx !== f.seq[b]) begin
                        ok      = 1'b0;
                        got_bit = uart_tx;
                    end
                end
                n_checks++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL frame%0d_bit%0d: got uart_tx=%0b, expected %0b for %0d cycles",
                             frame_idx, b, got_bit, f.seq[b], f.baud + 1);
                end
            end
            frames_done++;
            frame_idx++;
            if (f.btb) begin
                @(negedge sys_clk);
                chk("btb_idle_gap", 32'(uart_tx), 1);
                @(negedge sys_clk);
                chk("btb_next_start", 32'(uart_tx), 0);
                started = (uart_tx === 1'b0);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [7:0] d;
        sys_rst       = 1'b1;
        uart_baud_wr  = 1'b0;
        uart_con_wr   = 1'b0;
        uart_txbuf_wr = 1'b0;
        uart_sta_wr   = 1'b0;
        icb_wdat      = '0;

        // Reset values
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("rst_tx", 32'(uart_tx), 1);
        chk("rst_sta", 32'(uart_sta), 32'h0020);
        chk("rst_int", 32'(uart_int), 0);
        chk("rst_con", 32'(uart_con), 0);
        chk("rst_baud", 32'(uart_baud), 0);

        // 8N1, 4 cycles/bit, byte A5; ie_done enabled so the interrupt can be observed
        reg_wr(SelBaud, 16'd3);
        expect_frame(3, 10, 12'({1'b1, 8'hA5, 1'b0}), 1'b0);
        reg_wr(SelTxbuf, 16'h00A5);
        chk("push_count", 32'(uart_sta[15:8]), 1);
        reg_wr(SelCon, 16'h0071);
        chk("con_readback", 32'(uart_con), 32'h0071);
        chk("uart_en", 32'(uart_en), 1);
        wait_frames(1, 100, "wait_8n1");
        chk("done_before_set", 32'(uart_sta[0]), 0);
        @(negedge sys_clk);
        chk("done_set", 32'(uart_sta[0]), 1);
        chk("int_lag", 32'(uart_int), 0);
        chk("empty_evt_8n1", 32'(uart_sta[1]), 1);
        @(negedge sys_clk);
        chk("int_set", 32'(uart_int), 1);

        // 7 data bits, odd parity, 2 stop bits: A5 -> 7'h25, parity 0
        reg_wr(SelSta, 16'h0007);
        reg_wr(SelCon, 16'h002F);
        expect_frame(3, 11, 12'({2'b11, 1'b0, 7'h25, 1'b0}), 1'b0);
        reg_wr(SelTxbuf, 16'h00A5);
        wait_frames(2, 150, "wait_7o2");
        repeat (2) @(negedge sys_clk);
        // Same with even parity: parity bit 1
        reg_wr(SelCon, 16'h002B);
        expect_frame(3, 11, 12'({2'b11, 1'b1, 7'h25, 1'b0}), 1'b0);
        reg_wr(SelTxbuf, 16'h00A5);
        wait_frames(3, 150, "wait_7e2");
        repeat (2) @(negedge sys_clk);

        // Overflow: 17 pushes with en=0, byte 17 dropped, then 16 back-to-back frames
        reg_wr(SelCon, 16'h0130);
        reg_wr(SelBaud, 16'd1);
        reg_wr(SelSta, 16'h0007);
        for (int i = 0; i < 17; i++) begin
            d = 8'(i * 37 + 5);
            if (i < 16) expect_frame(1, 10, 12'({1'b1, d, 1'b0}), i != 15);
            reg_wr(SelTxbuf, {8'h00, d});
        end
        chk("full_sta", 32'(uart_sta), 32'h1014);
        @(negedge sys_clk);
        chk("ovf_int", 32'(uart_int), 1);
        reg_wr(SelCon, 16'h0031);
        wait_frames(19, 500, "wait_16_frames");
        @(negedge sys_clk);
        chk("drained_sta", 32'(uart_sta), 32'h0027);

        // Mid-frame baud change: frame 1 keeps 4 cycles/bit, frame 2 uses 8
        reg_wr(SelSta, 16'h0007);
        reg_wr(SelBaud, 16'd3);
        expect_frame(3, 10, 12'({1'b1, 8'h3C, 1'b0}), 1'b1);
        expect_frame(7, 10, 12'({1'b1, 8'hC3, 1'b0}), 1'b0);
        reg_wr(SelTxbuf, 16'h003C);
        reg_wr(SelTxbuf, 16'h00C3);
        repeat (8) @(negedge sys_clk);
        reg_wr(SelBaud, 16'd7);
        chk("baud_readback", 32'(uart_baud), 7);
        wait_frames(21, 300, "wait_baud_change");

        // Flush mid-frame: frame 1 completes, frame 2 never sent
        reg_wr(SelBaud, 16'd1);
        expect_frame(1, 10, 12'({1'b1, 8'h5A, 1'b0}), 1'b0);
        reg_wr(SelTxbuf, 16'h005A);
        reg_wr(SelTxbuf, 16'h0096);
        repeat (3) @(negedge sys_clk);
        reg_wr(SelCon, 16'h0231);
        chk("flush_reads_0", 32'(uart_con), 32'h0031);
        chk("flush_count", 32'(uart_sta[15:8]), 0);
        chk("flush_busy", 32'(uart_sta[3]), 1);
        wait_frames(22, 100, "wait_flush_frame");
        repeat (40) @(negedge sys_clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        // Clear collides with done event: done stays set
        reg_wr(SelCon, 16'h0071);
        reg_wr(SelSta, 16'h0007);
        repeat (2) @(negedge sys_clk);
        expect_frame(1, 10, 12'({1'b1, 8'h81, 1'b0}), 1'b0);
        reg_wr(SelTxbuf, 16'h0081);
        wait_frames(23, 100, "wait_collision_frame");
        icb_wdat    = 16'h0001;
        uart_sta_wr = 1'b1;
        @(negedge sys_clk);
        uart_sta_wr = 1'b0;
        icb_wdat    = '0;
        chk("collision_done", 32'(uart_sta[0]), 1);
        chk("collision_int_lag", 32'(uart_int), 0);
        @(negedge sys_clk);
        chk("collision_int", 32'(uart_int), 1);
        repeat (3) @(negedge sys_clk);
        reg_wr(SelSta, 16'h0001);
        chk("clear_done", 32'(uart_sta[0]), 0);
        chk("int_holds_one_cycle", 32'(uart_int), 1);
        @(negedge sys_clk);
        chk("int_dropped", 32'(uart_int), 0);

        repeat (20) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
